// File: rtl/irq_pkg.sv
// Shared types and constants for the eight-source interrupt controller.
package irq_pkg;

   localparam int NREQ = 8;
   localparam int ID_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SERV = 2'd2
   } irq_state_t;

   function automatic logic [NREQ-1:0] onehot(input logic [ID_W-1:0] id);
      logic [NREQ-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/prio_enc_8.sv
// Fixed-priority 8-to-3 encoder; bit 7 wins, all-zero input gives id 0.
module prio_enc_8
   import irq_pkg::*;
(
   input  logic [NREQ-1:0] in,
   output logic [ID_W-1:0] id,
   output logic            valid
);

   always_comb begin
      id    = '0;
      valid = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (in[i]) begin
            id    = ID_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_ctrl_8.sv
// Interrupt controller: edge-latched pending bits, mask, and a
// valid/ack/eoi offer FSM with an ack timeout.
module irq_ctrl_8
   import irq_pkg::*;
#(
   parameter int ACK_TIMEOUT = 15
)(
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            mask_wr,
   input  logic [NREQ-1:0] mask_wdata,
   output logic [NREQ-1:0] mask,
   output logic [NREQ-1:0] pending,
   output logic            irq_valid,
   output logic [ID_W-1:0] irq_id,
   input  logic            irq_ack,
   input  logic            eoi,
   output logic            busy,
   output logic            timeout
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'(ACK_TIMEOUT - 1);

   irq_state_t      r_state;
   irq_state_t      w_nxt;
   logic [NREQ-1:0] r_req_q;
   logic [NREQ-1:0] r_pend;
   logic [NREQ-1:0] r_mask;
   logic [ID_W-1:0] r_id;
   logic [TW-1:0]   r_timer;
   logic            r_valid;
   logic            r_busy;
   logic            r_tmo;

   logic [NREQ-1:0] w_edge;
   logic [NREQ-1:0] w_elig;
   logic [NREQ-1:0] w_clr;
   logic [ID_W-1:0] w_eid;
   logic [ID_W-1:0] w_idnxt;
   logic [TW-1:0]   w_tnxt;
   logic            w_any;
   logic            w_tmo;

   assign w_edge = req & ~r_req_q;
   assign w_elig = r_pend & ~r_mask;

   prio_enc_8 u_enc (
      .in    (w_elig),
      .id    (w_eid),
      .valid (w_any)
   );

   always_comb begin
      w_nxt   = r_state;
      w_idnxt = r_id;
      w_tnxt  = r_timer;
      w_clr   = '0;
      w_tmo   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_any) begin
               w_nxt   = REQ;
               w_idnxt = w_eid;
               w_tnxt  = '0;
            end
         end
         REQ: begin
            if (irq_ack) begin
               w_clr = onehot(r_id);
               w_nxt = SERV;
            end else if (r_timer == TLAST) begin
               // pending bit stays set so the source is re-offered
               w_nxt = IDLE;
               w_tmo = 1'b1;
            end else begin
               w_tnxt = r_timer + 1'b1;
            end
         end
         SERV: begin
            if (eoi) w_nxt = IDLE;
         end
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_req_q <= '0;
         r_pend  <= '0;
         r_mask  <= '1;
         r_id    <= '0;
         r_timer <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_tmo   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_req_q <= req;
         // a new edge beats the ack clear on the same bit
         r_pend  <= (r_pend & ~w_clr) | w_edge;
         if (mask_wr) r_mask <= mask_wdata;
         r_id    <= w_idnxt;
         r_timer <= w_tnxt;
         r_valid <= (w_nxt == REQ);
         r_busy  <= (w_nxt == SERV);
         r_tmo   <= w_tmo;
      end
   end

   assign mask      = r_mask;
   assign pending   = r_pend;
   assign irq_valid = r_valid;
   assign irq_id    = r_id;
   assign busy      = r_busy;
   assign timeout   = r_tmo;

endmodule

// File: tb/tb_irq_ctrl_8.sv
// Self-checking bench for irq_ctrl_8: direct checks plus an offer-id
// scoreboard popped whenever irq_valid rises.
module tb_irq_ctrl_8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       mask_wr;
   logic [7:0] mask_wdata;
   logic [7:0] mask;
   logic [7:0] pending;
   logic       irq_valid;
   logic [2:0] irq_id;
   logic       irq_ack;
   logic       eoi;
   logic       busy;
   logic       timeout;

   int n_chk = 0;
   int n_err = 0;
   int exp_q[$];
   logic prev_valid = 1'b0;

   always #5 clk = ~clk;

   irq_ctrl_8 #(.ACK_TIMEOUT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .mask_wr    (mask_wr),
      .mask_wdata (mask_wdata),
      .mask       (mask),
      .pending    (pending),
      .irq_valid  (irq_valid),
      .irq_id     (irq_id),
      .irq_ack    (irq_ack),
      .eoi        (eoi),
      .busy       (busy),
      .timeout    (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: each new offer must match the oldest expected id
   always @(negedge clk) begin
      if (irq_valid && !prev_valid) begin
         if (exp_q.size() == 0) chk("sb_unexpected", 32'd1, 32'd0);
         else chk("sb_id", {29'd0, irq_id}, exp_q.pop_front());
      end
      prev_valid = irq_valid;
   end

   task automatic do_reset();
      rst = 1'b1;
      req = 8'h00;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wr_mask(input logic [7:0] m);
      mask_wr    = 1'b1;
      mask_wdata = m;
      tick();
      mask_wr    = 1'b0;
   endtask

   task automatic serve();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      eoi     = 1'b1;
      tick();
      eoi     = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      req        = 8'hFF;
      mask_wr    = 1'b0;
      mask_wdata = 8'h00;
      irq_ack    = 1'b0;
      eoi        = 1'b0;
      #1;

      // reset with all lines high
      tick();
      tick();
      chk("rst_mask", mask, 8'hFF);
      chk("rst_pend", pending, 8'h00);
      chk("rst_valid", irq_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;
      tick();
      chk("post_rst_pend", pending, 8'hFF);
      tick();
      chk("post_rst_novalid", irq_valid, 1'b0);

      // priority
      do_reset();
      wr_mask(8'h00);
      chk("mask_wr", mask, 8'h00);
      req = 8'h24;
      exp_q.push_back(5);
      tick();
      req = 8'h00;
      chk("prio_pend", pending, 8'h24);
      chk("prio_lat1", irq_valid, 1'b0);
      tick();
      chk("prio_valid", irq_valid, 1'b1);
      chk("prio_id", irq_id, 3'd5);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk("ack_pend", pending, 8'h04);
      chk("ack_busy", busy, 1'b1);
      chk("ack_valid", irq_valid, 1'b0);
      exp_q.push_back(2);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      chk("eoi_busy", busy, 1'b0);
      chk("eoi_gap", irq_valid, 1'b0);
      tick();
      chk("prio2_valid", irq_valid, 1'b1);
      chk("prio2_id", irq_id, 3'd2);
      serve();
      chk("prio2_pend", pending, 8'h00);

      // ack timeout
      req = 8'h02;
      exp_q.push_back(1);
      tick();
      req = 8'h00;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("to_valid", irq_valid, 1'b1);
         chk("to_notmo", timeout, 1'b0);
         if (i < 3) tick();
      end
      exp_q.push_back(1);
      tick();
      chk("to_drop", irq_valid, 1'b0);
      chk("to_pulse", timeout, 1'b1);
      chk("to_pend", pending, 8'h02);
      tick();
      chk("to_once", timeout, 1'b0);
      chk("to_reoffer", irq_valid, 1'b1);
      chk("to_reid", irq_id, 3'd1);
      serve();

      // masking
      wr_mask(8'h80);
      req = 8'h80;
      tick();
      req = 8'h00;
      tick();
      chk("msk_pend", pending, 8'h80);
      chk("msk_novalid", irq_valid, 1'b0);
      exp_q.push_back(7);
      wr_mask(8'h00);
      chk("msk_lat", irq_valid, 1'b0);
      tick();
      chk("msk_valid", irq_valid, 1'b1);
      chk("msk_id", irq_id, 3'd7);
      serve();

      // set/clear collision
      req = 8'h08;
      exp_q.push_back(3);
      tick();
      req = 8'h00;
      tick();
      chk("col_valid", irq_valid, 1'b1);
      irq_ack = 1'b1;
      req     = 8'h08;
      tick();
      irq_ack = 1'b0;
      req     = 8'h00;
      chk("col_pend", pending, 8'h08);
      chk("col_busy", busy, 1'b1);
      exp_q.push_back(3);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      tick();
      chk("col_reoffer", irq_valid, 1'b1);
      chk("col_id", irq_id, 3'd3);
      serve();

      // reset while in service
      req = 8'h90;
      exp_q.push_back(7);
      tick();
      req = 8'h00;
      tick();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk("ms_busy", busy, 1'b1);
      chk("ms_pend", pending, 8'h10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("ms_rst_busy", busy, 1'b0);
      chk("ms_rst_pend", pending, 8'h00);
      chk("ms_rst_mask", mask, 8'hFF);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      chk("ms_eoi_busy", busy, 1'b0);
      chk("ms_eoi_valid", irq_valid, 1'b0);
      tick();
      chk("ms_idle", irq_valid, 1'b0);

      chk("sb_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
